// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: redirect/stall controls from decode/execute, and the
// PC, validity and statistics outputs of the fetch unit.
interface fetch_pc_unit_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_en;
  logic [31:0] jump_target;
  logic [31:0] PC_out;
  logic [31:0] pc_fetch;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        misalign_err;
  logic [31:0] retire_cnt;
  logic [31:0] bubble_cnt;

  // Fetch unit side
  modport master (
    input  stall, branch_taken, branch_target, jump_en, jump_target,
    output PC_out, pc_fetch, pc_plus4, inst_valid, misalign_err,
           retire_cnt, bubble_cnt
  );

  // Consumer (decode/execute) side
  modport slave (
    output stall, branch_taken, branch_target, jump_en, jump_target,
    input  PC_out, pc_fetch, pc_plus4, inst_valid, misalign_err,
           retire_cnt, bubble_cnt
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter / fetch-control stage. PC_out addresses a synchronous
// instruction memory; pc_fetch tracks the PC of the word now on its output.
// Redirects and stalls kill the word fetched on the same edge (one bubble).
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = 4,
  parameter int          ADDR_BITS = 10
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_unit_if.master bus
);

  localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_BITS) - 64'd1);
  localparam logic [31:0] STEP      = 32'(PC_STEP);
  localparam logic [31:0] PC_INIT   = RESET_PC & ADDR_MASK;

  logic [31:0] pc_out_reg,   pc_out_next;
  logic [31:0] pc_fetch_reg;
  logic        valid_reg,    valid_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] retire_reg,   retire_next;
  logic [31:0] bubble_reg,   bubble_next;

  logic        redirect;
  logic        accept;
  logic [31:0] target_raw;

  // Next-PC selection: jump > branch > replay > sequential; controls only count on valid cycles
  always_comb begin
    redirect      = valid_reg && (bus.jump_en || bus.branch_taken);
    target_raw    = bus.jump_en ? bus.jump_target : bus.branch_target;
    accept        = valid_reg && (redirect || !bus.stall);
    pc_out_next   = (pc_out_reg + STEP) & ADDR_MASK;
    valid_next    = 1'b1;
    misalign_next = 1'b0;
    if (redirect) begin
      pc_out_next   = target_raw & ADDR_MASK & ~32'h3;
      valid_next    = 1'b0;
      misalign_next = |target_raw[1:0];
    end else if (valid_reg && bus.stall) begin
      // Re-fetch the stalled word; the one arriving next cycle is discarded
      pc_out_next = pc_fetch_reg;
      valid_next  = 1'b0;
    end
    retire_next = retire_reg + {31'd0, accept};
    bubble_next = bubble_reg + {31'd0, ~valid_reg};
  end

  // State registers; pc_fetch follows PC_out because memory samples it on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_out_reg   <= PC_INIT;
      pc_fetch_reg <= PC_INIT;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      retire_reg   <= 32'd0;
      bubble_reg   <= 32'd0;
    end else begin
      pc_out_reg   <= pc_out_next;
      pc_fetch_reg <= pc_out_reg;
      valid_reg    <= valid_next;
      misalign_reg <= misalign_next;
      retire_reg   <= retire_next;
      bubble_reg   <= bubble_next;
    end
  end

  assign bus.PC_out       = pc_out_reg;
  assign bus.pc_fetch     = pc_fetch_reg;
  assign bus.pc_plus4     = (pc_fetch_reg + STEP) & ADDR_MASK;
  assign bus.inst_valid   = valid_reg;
  assign bus.misalign_err = misalign_reg;
  assign bus.retire_cnt   = retire_reg;
  assign bus.bubble_cnt   = bubble_reg;

endmodule
